// File: rtl/sseg_pkg.sv
// Shared seven-segment constants and the hex glyph decoder.
package sseg_pkg;

   // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0..F
   localparam logic [0:15][6:0] SEG_LUT = {
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Active-low pin pattern with every segment dark
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      return SEG_LUT[nib];
   endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1 and flags the last clock of each slot.
module sseg_prescaler #(
   parameter int DIV = 4,
   parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] count,
   output logic          slot_end
);

   assign slot_end = (count == CW'(DIV - 1));

   // Wrap to zero at the end of each slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           count <= '0;
      else if (slot_end) count <= '0;
      else               count <= count + CW'(1);
   end

endmodule

// File: rtl/sseg_scan_n.sv
// N-digit multiplexed common-anode seven-segment driver with hex decode,
// per-digit enable/dp, leading-zero blanking and frame-synchronous double buffering.
module sseg_scan_n
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_HZ       = 100_000_000,
   parameter int DIGIT_HZ     = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_blank,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_tick
);

   localparam int DIV = CLK_HZ / DIGIT_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   if (DIV < 2) begin : g_bad_div
      $error("sseg_scan_n: CLK_HZ/DIGIT_HZ must be at least 2");
   end
   if (BLANK_CYCLES >= DIV) begin : g_bad_blank
      $error("sseg_scan_n: BLANK_CYCLES must be less than CLK_HZ/DIGIT_HZ");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_n
      $error("sseg_scan_n: NUM_DIGITS must be 1..8");
   end

   logic [CW-1:0]           pcnt;
   logic                    slot_end;
   logic [IW-1:0]           idx;
   logic                    wrap;
   logic [4*NUM_DIGITS-1:0] stg_val, act_val;
   logic [NUM_DIGITS-1:0]   stg_dp, act_dp, stg_en, act_en;
   logic                    pending;
   logic [NUM_DIGITS-1:0]   lz_mask, blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_blank;
   logic [NUM_DIGITS-1:0]   an_nxt;

   sseg_prescaler #(.DIV(DIV), .CW(CW)) u_pre (
      .clk      (clk),
      .rst      (rst),
      .count    (pcnt),
      .slot_end (slot_end)
   );

   assign wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));

   // Digit index advances once per slot; frame_tick marks the cycle index returns to 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= wrap;
         if (slot_end) idx <= wrap ? '0 : idx + IW'(1);
      end
   end

   // Staging captures on load; active only swaps at a frame boundary so a frame never tears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_val <= '0; stg_dp <= '0; stg_en <= '0;
         act_val <= '0; act_dp <= '0; act_en <= '0;
         pending <= 1'b0;
      end else begin
         if (wrap && pending) begin
            act_val <= stg_val;
            act_dp  <= stg_dp;
            act_en  <= stg_en;
         end
         if (load) begin
            stg_val <= value;
            stg_dp  <= dp_in;
            stg_en  <= digit_en;
         end
         if (load)      pending <= 1'b1;
         else if (wrap) pending <= 1'b0;
      end
   end

   // Digit k is a leading zero when it and every digit above it hold 0; digit 0 always shows
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
      if (k == 0) begin : g_lsd
         assign lz_mask[k] = 1'b0;
      end else begin : g_upper
         assign lz_mask[k] = lz_blank && (act_val[4*NUM_DIGITS-1:4*k] == '0);
      end
   end

   assign blank = ~act_en | lz_mask;

   // Select the current digit's data and anode pattern
   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      an_nxt    = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib   = act_val[4*i +: 4];
            cur_dp    = act_dp[i];
            cur_blank = blank[i];
            if (pcnt >= CW'(BLANK_CYCLES)) an_nxt[i] = 1'b0;
         end
      end
   end

   // Registered pin drivers; a blanked digit keeps its anode strobe but lights nothing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= '1;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= cur_blank ? SEG_BLANK : ~seg_decode(cur_nib);
         dp  <= cur_blank ? 1'b1 : ~cur_dp;
      end
   end

endmodule

// File: tb/tb_sseg_scan_n.sv
// Randomised bench for sseg_scan_n (N=4, DIV=4, one blank clock per slot).
module tb_sseg_scan_n;

   logic        clk, rst;
   logic [15:0] value;
   logic [3:0]  dp_in, digit_en;
   logic        lz_blank, load;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   sseg_scan_n #(.NUM_DIGITS(4), .CLK_HZ(8), .DIGIT_HZ(2), .BLANK_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
      .lz_blank(lz_blank), .load(load), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   localparam logic [12:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

   // Reference model: the scan position is a pure function of clocks since reset
   int          m_t, m_p, m_d, m_lead;
   logic [15:0] m_stg_val, m_act_val;
   logic [3:0]  m_stg_dp, m_act_dp, m_stg_en, m_act_en;
   logic        m_pend, m_blank, m_wrap;
   logic [3:0]  m_nib;
   logic [12:0] exp_out;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_pend = 0;
         m_stg_val = 0; m_stg_dp = 0; m_stg_en = 0;
         m_act_val = 0; m_act_dp = 0; m_act_en = 0;
         exp_out = RST_OUT;
      end else begin
         m_p = m_t % 4;
         m_d = (m_t / 4) % 4;
         m_wrap = (m_t % 16) == 15;
         m_lead = 0;
         for (int k = 0; k < 4; k++) if (m_act_val[4*k +: 4] != 0) m_lead = k;
         m_nib = m_act_val[4*m_d +: 4];
         m_blank = !m_act_en[m_d] || (lz_blank && m_d > m_lead);
         exp_out = {(m_p >= 1) ? ~(4'b0001 << m_d) : 4'hF,
                    m_blank ? 7'h7F : ~LUT[m_nib],
                    m_blank ? 1'b1 : ~m_act_dp[m_d],
                    m_wrap};
         if (m_wrap && m_pend) begin
            m_act_val = m_stg_val; m_act_dp = m_stg_dp; m_act_en = m_stg_en; m_pend = 0;
         end
         if (load) begin
            m_stg_val = value; m_stg_dp = dp_in; m_stg_en = digit_en; m_pend = 1;
         end
         m_t++;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
         lz_blank = 1'($urandom); load = 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== RST_OUT) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", {an, seg, dp, frame_tick}, RST_OUT);
         end
      end
      load = 1'b0; lz_blank = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF) begin n_bad++; $display("FAIL first_an_blank: got %b want 1111", an); end
      @(negedge clk);
      n_cmp++;
      if (an !== 4'b1110) begin n_bad++; $display("FAIL first_an_low: got %b want 1110", an); end
      repeat (20) begin
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== exp_out) begin
            n_bad++;
            $display("FAIL post_reset: got %h want %h", {an, seg, dp, frame_tick}, exp_out);
         end
      end
   endtask

   task automatic test_load();
      logic [6:0] want [4];
      bit ok;
      want = '{~7'h71, ~7'h77, ~7'h5B, ~7'h06};
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = frame_tick; end
      repeat (5) @(negedge clk);
      value = 16'h12AF; digit_en = 4'hF; dp_in = 4'b0010; lz_blank = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (40) begin
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== exp_out) begin
            n_bad++;
            $display("FAIL load_model: got %h want %h", {an, seg, dp, frame_tick}, exp_out);
         end
      end
      repeat (16) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (an == ~(4'b0001 << d)) begin
               n_cmp++;
               if (seg !== want[d] || dp !== (d != 1)) begin
                  n_bad++;
                  $display("FAIL load_digit%0d: got seg %h dp %b want seg %h dp %b", d, seg, dp, want[d], d != 1);
               end
            end
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [15:0] vals [2];
      vals = '{16'h0005, 16'h0000};
      for (int v = 0; v < 2; v++) begin
         value = vals[v]; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b1; load = 1'b1;
         @(negedge clk);
         load = 1'b0;
         repeat (40) begin
            @(negedge clk);
            n_cmp++;
            if ({an, seg, dp, frame_tick} !== exp_out) begin
               n_bad++;
               $display("FAIL lz_blank %h: got %h want %h", vals[v], {an, seg, dp, frame_tick}, exp_out);
            end
            if (an == 4'b1110) begin
               n_cmp++;
               if (seg !== ((v == 0) ? ~7'h6D : ~7'h3F)) begin
                  n_bad++;
                  $display("FAIL lz_digit0 %h: got %h", vals[v], seg);
               end
            end
         end
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_digit_en();
      value = 16'h8888; digit_en = 4'b0101; dp_in = 4'hF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (40) begin
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== exp_out) begin
            n_bad++;
            $display("FAIL digit_en: got %h want %h", {an, seg, dp, frame_tick}, exp_out);
         end
      end
   endtask

   task automatic test_timing();
      int low [4];
      int gap;
      bit ok;
      low = '{0, 0, 0, 0};
      repeat (32) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) if (an[d] == 1'b0) low[d]++;
      end
      for (int d = 0; d < 4; d++) begin
         n_cmp++;
         if (low[d] != 6) begin n_bad++; $display("FAIL anode_duty%0d: got %0d want 6", d, low[d]); end
      end
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = frame_tick; end
      gap = 0;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); gap++; ok = frame_tick; end
      n_cmp++;
      if (gap != 16) begin n_bad++; $display("FAIL frame_period: got %0d want 16", gap); end
      // Pending load mid-frame, then a second load landing exactly on the wrap edge
      repeat (5) @(negedge clk);
      value = 16'hABCD; digit_en = 4'hF; dp_in = 4'b0001; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (9) @(negedge clk);
      value = 16'h3579; dp_in = 4'b1000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (48) begin
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== exp_out) begin
            n_bad++;
            $display("FAIL wrap_load: got %h want %h", {an, seg, dp, frame_tick}, exp_out);
         end
      end
   endtask

   task automatic test_random();
      repeat (400) begin
         value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom | $urandom);
         if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
         if ($urandom_range(0, 7) == 0) lz_blank = 1'($urandom);
         load = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== exp_out) begin
            n_bad++;
            $display("FAIL random: got %h want %h", {an, seg, dp, frame_tick}, exp_out);
         end
      end
      load = 1'b0;
   endtask

   task automatic test_async_reset();
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = (an == 4'b1011); end
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL find_digit2: got %b want 1011", an); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({an, seg, dp, frame_tick} !== RST_OUT) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", {an, seg, dp, frame_tick}, RST_OUT);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (24) begin
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame_tick} !== exp_out) begin
            n_bad++;
            $display("FAIL restart: got %h want %h", {an, seg, dp, frame_tick}, exp_out);
         end
      end
   endtask

   initial begin
      rst = 1'b1; value = '0; dp_in = '0; digit_en = '0; lz_blank = 1'b0; load = 1'b0;
      test_reset();
      test_load();
      test_lz_blank();
      test_digit_en();
      test_timing();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
